// File: rtl/i2c_slave_target.sv
// i2c_slave_target: I2C target (responder) with 7-bit addressing.
//   Oversamples SCL/SDA on i_clk through 2-flop synchronizers and detects
//   edges, START and STOP. It ACKs its own address, passes written bytes to
//   the core and serves read bytes from the core, including multi-byte bursts.
// Optional feature macro: I2C_CLK_STRETCH_EN
//   When defined, this adds the i_tx_valid input. At each read-byte load point
//   the target holds SCL low until the core raises i_tx_valid.
// Ports:
//   i_clk       system clock; the SCL period must be >= 8 i_clk periods
//   i_rst_n     asynchronous reset, active low
//   i_tx_data   read-data byte, sampled at the SCL fall that begins a read byte
//   i_tx_valid  (I2C_CLK_STRETCH_EN only) i_tx_data is ready
//   o_rx_data   last byte written by the master
//   o_rx_valid  one-clk pulse when o_rx_data updates
//   o_tx_req    one-clk pulse; the core must present the next i_tx_data
//   o_rw        R/W bit of the current transfer (1 = read)
//   o_busy      high from START to STOP
//   o_state     FSM state, for debug
//   io_i2c_sda  open-drain data line (drives 0 or z)
//   io_i2c_scl  clock line (driven low only while stretching)
module i2c_slave_target #(
  parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_tx_data,
`ifdef I2C_CLK_STRETCH_EN
  input  logic       i_tx_valid,
`endif
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_tx_req,
  output logic       o_rw,
  output logic       o_busy,
  output logic [3:0] o_state,
  inout  wire        io_i2c_sda,
  inout  wire        io_i2c_scl
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ADDR      = 4'd1,
    S_ADDR_ACK  = 4'd2,
    S_WRITE     = 4'd3,
    S_WRITE_ACK = 4'd4,
    S_READ      = 4'd5,
    S_READ_ACK  = 4'd6,
    S_WAIT_STOP = 4'd7
  } state_t;

  state_t     r_state;
  logic [2:0] r_scl_sync, r_sda_sync;   // [1] is the synced value, [2] is its previous value
  logic [2:0] r_bit_cnt;
  logic [6:0] r_shift;
  logic [7:0] r_tx_shift;
  logic [7:0] r_rx_data;
  logic       r_rx_valid, r_tx_req, r_rw, r_busy;
  logic       r_sda_oe, r_scl_oe;
  logic       r_rd_more;                // master ACKed a read byte; load the next one on the fall

  logic w_sda, w_rise, w_fall, w_start, w_stop, w_tx_ok;

  assign w_sda   = r_sda_sync[1];
  assign w_rise  =  r_scl_sync[1] & ~r_scl_sync[2];
  assign w_fall  = ~r_scl_sync[1] &  r_scl_sync[2];
  assign w_start =  r_scl_sync[1] &  r_scl_sync[2] &  r_sda_sync[2] & ~r_sda_sync[1];
  assign w_stop  =  r_scl_sync[1] &  r_scl_sync[2] & ~r_sda_sync[2] &  r_sda_sync[1];

`ifdef I2C_CLK_STRETCH_EN
  assign w_tx_ok    = i_tx_valid;
  assign io_i2c_scl = r_scl_oe ? 1'b0 : 1'bz;
`else
  assign w_tx_ok    = 1'b1;
  assign io_i2c_scl = 1'bz;
`endif

  assign io_i2c_sda = r_sda_oe ? 1'b0 : 1'bz;

  assign o_rx_data  = r_rx_data;
  assign o_rx_valid = r_rx_valid;
  assign o_tx_req   = r_tx_req;
  assign o_rw       = r_rw;
  assign o_busy     = r_busy;
  assign o_state    = r_state;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_scl_sync <= 3'b111;
      r_sda_sync <= 3'b111;
    end else begin
      r_scl_sync <= {r_scl_sync[1:0], io_i2c_scl};
      r_sda_sync <= {r_sda_sync[1:0], io_i2c_sda};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= 3'd7;
      r_shift    <= '0;
      r_tx_shift <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_tx_req   <= 1'b0;
      r_rw       <= 1'b0;
      r_busy     <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_scl_oe   <= 1'b0;
      r_rd_more  <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_tx_req   <= 1'b0;
      if (w_start) begin
        // A repeated START also lands here; any partial byte is dropped.
        r_state   <= S_ADDR;
        r_bit_cnt <= 3'd7;
        r_busy    <= 1'b1;
        r_sda_oe  <= 1'b0;
        r_scl_oe  <= 1'b0;
        r_rd_more <= 1'b0;
      end else if (w_stop) begin
        r_state   <= S_IDLE;
        r_busy    <= 1'b0;
        r_sda_oe  <= 1'b0;
        r_scl_oe  <= 1'b0;
        r_rd_more <= 1'b0;
      end else if (r_scl_oe) begin
        // We hold SCL low, so no edges arrive; wait here for the core's byte.
        if (w_tx_ok) begin
          r_tx_shift <= i_tx_data;
          r_sda_oe   <= ~i_tx_data[7];
          r_bit_cnt  <= 3'd7;
          r_scl_oe   <= 1'b0;
          r_state    <= S_READ;
        end
      end else begin
        case (r_state)
          S_ADDR: if (w_rise) begin
            r_shift   <= {r_shift[5:0], w_sda};
            r_bit_cnt <= r_bit_cnt - 3'd1;
            if (r_bit_cnt == 3'd0) begin
              r_rw <= w_sda;
              if (r_shift == SLAVE_ADDR) begin
                r_state  <= S_ADDR_ACK;
                r_tx_req <= w_sda;
              end else begin
                r_state  <= S_WAIT_STOP;
              end
            end
          end
          // First fall: drive the ACK. Second fall: the ACK slot is over.
          S_ADDR_ACK: if (w_fall) begin
            if (!r_sda_oe) begin
              r_sda_oe <= 1'b1;
            end else if (!r_rw) begin
              r_sda_oe <= 1'b0;
              r_state  <= S_WRITE;
            end else if (w_tx_ok) begin
              r_tx_shift <= i_tx_data;
              r_sda_oe   <= ~i_tx_data[7];
              r_bit_cnt  <= 3'd7;
              r_state    <= S_READ;
            end else begin
              r_sda_oe <= 1'b0;
              r_scl_oe <= 1'b1;
            end
          end
          S_WRITE: if (w_rise) begin
            r_shift   <= {r_shift[5:0], w_sda};
            r_bit_cnt <= r_bit_cnt - 3'd1;
            if (r_bit_cnt == 3'd0) begin
              r_rx_data  <= {r_shift, w_sda};
              r_rx_valid <= 1'b1;
              r_state    <= S_WRITE_ACK;
            end
          end
          S_WRITE_ACK: if (w_fall) begin
            if (!r_sda_oe) begin
              r_sda_oe <= 1'b1;
            end else begin
              r_sda_oe <= 1'b0;
              r_state  <= S_WRITE;
            end
          end
          S_READ: begin
            if (w_rise) begin
              r_bit_cnt <= r_bit_cnt - 3'd1;
            end else if (w_fall) begin
              // bit_cnt has wrapped back to 7 only after the bit-0 rise.
              if (r_bit_cnt == 3'd7) begin
                r_sda_oe <= 1'b0;
                r_state  <= S_READ_ACK;
              end else begin
                r_sda_oe <= ~r_tx_shift[r_bit_cnt];
              end
            end
          end
          S_READ_ACK: begin
            if (w_rise) begin
              if (!w_sda) begin
                r_tx_req  <= 1'b1;
                r_rd_more <= 1'b1;
              end else begin
                r_state   <= S_WAIT_STOP;
              end
            end else if (w_fall && r_rd_more) begin
              r_rd_more <= 1'b0;
              if (w_tx_ok) begin
                r_tx_shift <= i_tx_data;
                r_sda_oe   <= ~i_tx_data[7];
                r_bit_cnt  <= 3'd7;
                r_state    <= S_READ;
              end else begin
                r_scl_oe <= 1'b1;
              end
            end
          end
          default: ;  // IDLE and WAIT_STOP leave only on START or STOP
        endcase
      end
    end
  end

endmodule
